// File: rtl/pkt_egress_buffer_pkg.sv
// Shared types and default widths for the store-and-forward egress packet buffer.
// Also hosts the saturating counter helper used when EGRESS_BUFFER_STATS_EN is defined.
package pkt_egress_buffer_pkg;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    WRITE    = 2'd1,
    DROP     = 2'd2
  } ingress_state_t;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_KEEP_WIDTH  = 32;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/egress_beat_ram.sv
// Simple dual-port beat storage: one write port, one read port with a registered,
// enable-gated read so the read register doubles as the egress output register.
module egress_beat_ram #(
  parameter int ADDR_BITS = 6,
  parameter int WIDTH     = 417
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_egress_buffer.sv
// Store-and-forward egress buffer: packets are released only once fully stored; overflow drops
// the packet instead of back-pressuring. Define EGRESS_BUFFER_STATS_EN for pass/drop counters.
module pkt_egress_buffer
  import pkt_egress_buffer_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int DEPTH_BITS           = 6,
  parameter int PKT_DEPTH_BITS       = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready
`ifdef EGRESS_BUFFER_STATS_EN
  ,
  output logic [31:0]                       pass_cnt,
  output logic [31:0]                       drop_cnt
`endif
);

  localparam int DATA_W = C_S_AXIS_DATA_WIDTH;
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int USER_W = C_S_AXIS_TUSER_WIDTH;
  localparam int BEAT_W = DATA_W + KEEP_W + USER_W + 1;
  localparam int PTR_W  = DEPTH_BITS + 1;
  localparam int CNT_W  = PKT_DEPTH_BITS + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  ingress_state_t   state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] pkt_cnt_reg;
  logic             out_valid_reg;

  logic              accept, full, can_store;
  logic              wr_en, commit, drop_start, rd_en, pop;
  logic [BEAT_W-1:0] wr_data, rd_data;

  assign s_axis_tready = ~reset;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full = (wr_ptr_reg[DEPTH_BITS] != rd_ptr_reg[DEPTH_BITS]) &&
                (wr_ptr_reg[DEPTH_BITS-1:0] == rd_ptr_reg[DEPTH_BITS-1:0]);
  assign can_store = !full && !pkt_cnt_reg[PKT_DEPTH_BITS];

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop_start = 1'b0;
    case (state_reg)
      WAIT_SOP, WRITE: begin
        if (accept) begin
          if (can_store) begin
            wr_en      = 1'b1;
            commit     = s_axis_tlast;
            state_next = s_axis_tlast ? WAIT_SOP : WRITE;
          end else begin
            drop_start = 1'b1;
            state_next = s_axis_tlast ? WAIT_SOP : DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) state_next = WAIT_SOP;
      end
      default: state_next = WAIT_SOP;
    endcase
  end

  // Only committed beats are ever read, which is what makes the buffer store-and-forward.
  assign rd_en = (pkt_cnt_reg != '0) && (rd_ptr_reg != commit_ptr_reg) &&
                 (!out_valid_reg || m_axis_tready);
  assign pop   = out_valid_reg && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= WAIT_SOP;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
      pkt_cnt_reg    <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (wr_en)           wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      else if (drop_start) wr_ptr_reg <= commit_ptr_reg;
      if (commit) commit_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_en)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (rd_en)              out_valid_reg <= 1'b1;
      else if (m_axis_tready) out_valid_reg <= 1'b0;
      case ({commit, pop})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - CNT_ONE;
        default: pkt_cnt_reg <= pkt_cnt_reg;
      endcase
    end
  end

  assign wr_data = {s_axis_tuser, s_axis_tkeep, s_axis_tdata, s_axis_tlast};

  egress_beat_ram #(
    .ADDR_BITS (DEPTH_BITS),
    .WIDTH     (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[DEPTH_BITS-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[DEPTH_BITS-1:0]),
    .rd_data (rd_data)
  );

  // The RAM read register is not reset, so outputs are masked until a beat is valid.
  always_comb begin
    m_axis_tvalid = out_valid_reg;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (out_valid_reg) begin
      {m_axis_tuser, m_axis_tkeep, m_axis_tdata, m_axis_tlast} = rd_data;
    end
  end

`ifdef EGRESS_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop)        pass_cnt <= sat_inc32(pass_cnt);
      if (drop_start) drop_cnt <= sat_inc32(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pkt_egress_buffer.sv
// Scoreboard bench for pkt_egress_buffer: stimulus pushes expected beats of packets that must
// pass; an independent monitor pops and compares every egress handshake and checks stall stability.
module tb_pkt_egress_buffer;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
`ifdef EGRESS_BUFFER_STATS_EN
  logic [31:0]  pass_cnt, drop_cnt;
`endif

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats_out = 0;

  always #5 clk = ~clk;

  pkt_egress_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
`ifdef EGRESS_BUFFER_STATS_EN
    ,
    .pass_cnt      (pass_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  function automatic beat_t make_beat(int pid, int idx, int len);
    beat_t b;
    for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = {pid[15:0], idx[7:0], w[7:0]};
    for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = {~pid[7:0], idx[7:0], 8'hA5, w[7:0]};
    b.last = (idx == len - 1);
    b.keep = b.last ? (32'hFFFF_FFFF >> (pid % 32)) : 32'hFFFF_FFFF;
    return b;
  endfunction

  task automatic chk(string name, logic [255:0] got, logic [255:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic send_pkt(int pid, int len, bit passes);
    for (int b = 0; b < len; b++) begin
      beat_t bt;
      bt = make_beat(pid, b, len);
      if (passes) exp_q.push_back(bt);
      s_axis_tdata  = bt.data;
      s_axis_tkeep  = bt.keep;
      s_axis_tuser  = bt.user;
      s_axis_tlast  = bt.last;
      s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    $display("sent pkt %0d len %0d expect %s", pid, len, passes ? "pass" : "drop");
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s drain: %0d beats still pending after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
    idle(4);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  // Monitor: every egress handshake must match the head of the scoreboard.
  logic         stall = 1'b0;
  logic [416:0] held;
  always @(negedge clk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        n_checks++;
        if (!m_axis_tvalid || {m_axis_tuser, m_axis_tkeep, m_axis_tdata, m_axis_tlast} !== held) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b last=%0b data=%0h, required held data=%0h",
                   m_axis_tvalid, m_axis_tlast, m_axis_tdata, held[256:1]);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        beats_out++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b, required no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
              m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
            n_fail++;
            $display("FAIL beat: got d=%0h k=%0h u=%0h l=%0b required d=%0h k=%0h u=%0h l=%0b",
                     m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast,
                     e.data, e.keep, e.user, e.last);
          end else begin
            $display("beat out d=%0h last=%0b", m_axis_tdata[31:0], m_axis_tlast);
          end
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tuser, m_axis_tkeep, m_axis_tdata, m_axis_tlast};
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    #3;
    chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    chk("rst_m_tdata", m_axis_tdata, 256'd0);
    chk("rst_m_tlast", 256'(m_axis_tlast), 256'd0);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("rst_drop_cnt", 256'(drop_cnt), 256'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("s_tready_after_rst", 256'(s_axis_tready), 256'd1);

    // 3-beat packet: first beat one cycle after the tlast edge, then back-to-back
    m_axis_tready = 1'b1;
    send_pkt(1, 3, 1'b1);
    chk("lat_no_early_valid", 256'(m_axis_tvalid), 256'd0);
    @(posedge clk); #1;
    chk("lat_beat0_valid", 256'({m_axis_tvalid, m_axis_tlast}), 256'b10);
    @(posedge clk); #1;
    chk("lat_beat1_valid", 256'({m_axis_tvalid, m_axis_tlast}), 256'b10);
    @(posedge clk); #1;
    chk("lat_beat2_last", 256'({m_axis_tvalid, m_axis_tlast}), 256'b11);
    drain("t3beat", 20);

    // 64 one-beat packets while stalled: only 16 fit in the packet count limit
    do_reset();
    m_axis_tready = 1'b0;
    for (int p = 0; p < 64; p++) send_pkt(100 + p, 1, p < 16);
    idle(3);
    chk("t64_head_held", 256'(m_axis_tvalid), 256'd1);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("t64_drop_cnt", 256'(drop_cnt), 256'd48);
`endif
    base = beats_out;
    m_axis_tready = 1'b1;
    drain("t64", 200);
    chk("t64_pkts_out", 256'(beats_out - base), 256'd16);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("t64_pass_cnt", 256'(pass_cnt), 256'd16);
`endif

    // 70-beat packet exceeds storage and is dropped; a 2-beat packet follows intact
    do_reset();
    m_axis_tready = 1'b1;
    base = beats_out;
    send_pkt(200, 70, 1'b0);
    idle(6);
    chk("t70_no_output", 256'(beats_out - base), 256'd0);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("t70_drop_cnt", 256'(drop_cnt), 256'd1);
`endif
    send_pkt(201, 2, 1'b1);
    drain("t70_follow", 20);

    // 40-beat packet held, 30-beat packet overflows storage and is dropped
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(300, 40, 1'b1);
    send_pkt(301, 30, 1'b0);
    idle(3);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("t40_drop_cnt", 256'(drop_cnt), 256'd1);
`endif
    m_axis_tready = 1'b1;
    drain("t40", 100);
`ifdef EGRESS_BUFFER_STATS_EN
    chk("t40_pass_cnt", 256'(pass_cnt), 256'd1);
`endif

    // Alternating tready over a 4-beat packet
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(400, 4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      m_axis_tready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b1;
    drain("ttoggle", 20);

    // Reset mid-packet discards a stored packet and the partial one
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(500, 2, 1'b0);
    begin
      beat_t bt;
      bt = make_beat(501, 0, 5);
      s_axis_tdata = bt.data; s_axis_tkeep = bt.keep; s_axis_tuser = bt.user;
      s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
      @(posedge clk); #1;
      bt = make_beat(501, 1, 5);
      s_axis_tdata = bt.data; s_axis_tkeep = bt.keep; s_axis_tuser = bt.user;
    end
    reset = 1'b1;
    #2;
    chk("midrst_s_tready", 256'(s_axis_tready), 256'd0);
    chk("midrst_m_tvalid", 256'(m_axis_tvalid), 256'd0);
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_axis_tready = 1'b1;
    base = beats_out;
    idle(5);
    chk("midrst_no_output", 256'(beats_out - base), 256'd0);
    send_pkt(502, 1, 1'b1);
    drain("tmidrst", 20);
    chk("midrst_one_beat", 256'(beats_out - base), 256'd1);

    chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
